// File: rtl/uart_frame_tx.sv
// Framed 8N1 UART transmitter: buffers a payload, then sends SOF 0xA5, LEN, payload, CHK.
// Define UART_FRAME_TX_CRC8_EN to make CHK a CRC-8 (poly 0x07) instead of an XOR.
module uart_frame_tx #(
    parameter int CLK_FREQ  = 20000000,
    parameter int BAUD_RATE = 125000,
    parameter int MAX_LEN   = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       s_valid_i,
    input  logic [7:0] s_data_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic       uart_tx_o,
    output logic       busy_o,
    output logic       trunc_o
);
    localparam int DIV    = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [2:0] {S_COLLECT, S_SOF, S_LEN, S_PAYLOAD, S_CHK} state_t;

    state_t            state;
    logic [7:0]        pay_buf [MAX_LEN];
    logic [7:0]        wr_cnt;
    logic [7:0]        len;
    logic [7:0]        rd_idx;
    logic [7:0]        shreg;
    logic [7:0]        chk;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic              accept;
    logic              closing;
    logic              baud_tick;
    logic              last_payload;
    logic [IDX_W-1:0]  rd_nxt;

    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_FRAME_TX_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
`else
        return acc ^ b;
`endif
    endfunction

    assign accept       = s_valid_i & s_ready_o;
    assign closing      = s_last_i | (wr_cnt == 8'(MAX_LEN - 1));
    assign trunc_o      = accept & ~s_last_i & (wr_cnt == 8'(MAX_LEN - 1));
    assign baud_tick    = (baud_cnt == BAUD_W'(DIV - 1));
    assign last_payload = (rd_idx == len - 8'd1);
    assign rd_nxt       = rd_idx[IDX_W-1:0] + IDX_W'(1);

    // NOTE: the payload buffer has no reset; wr_cnt/len decide which entries are valid,
    // and leaving it out keeps the array mappable onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (accept) pay_buf[wr_cnt[IDX_W-1:0]] <= s_data_i;
    end

    // NOTE: every state register below uses non-blocking assignment so all of them
    // update together from the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_COLLECT;
            uart_tx_o <= 1'b1;
            s_ready_o <= 1'b0;
            busy_o    <= 1'b0;
            wr_cnt    <= '0;
            len       <= '0;
            rd_idx    <= '0;
            shreg     <= '0;
            chk       <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
        end else if (state == S_COLLECT) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (!s_ready_o) begin
                s_ready_o <= 1'b1;
            end else if (s_valid_i) begin
                wr_cnt <= wr_cnt + 8'd1;
                if (closing) begin
                    // Start bit of SOF goes out on the very next cycle.
                    len       <= wr_cnt + 8'd1;
                    wr_cnt    <= '0;
                    s_ready_o <= 1'b0;
                    busy_o    <= 1'b1;
                    uart_tx_o <= 1'b0;
                    shreg     <= SOF_BYTE;
                    chk       <= '0;
                    state     <= S_SOF;
                end
            end
        end else if (!baud_tick) begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
        end else begin
            baud_cnt <= '0;
            if (bit_cnt != 4'd9) begin
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd8) begin
                    uart_tx_o <= 1'b1;
                end else begin
                    uart_tx_o <= shreg[0];
                    shreg     <= shreg >> 1;
                end
            end else begin
                // Stop bit done: next byte's start bit follows with no idle gap.
                bit_cnt   <= '0;
                uart_tx_o <= 1'b0;
                unique case (state)
                    S_SOF: begin
                        state <= S_LEN;
                        shreg <= len;
                        chk   <= chk_next(chk, len);
                    end
                    S_LEN: begin
                        state  <= S_PAYLOAD;
                        rd_idx <= '0;
                        shreg  <= pay_buf[0];
                        chk    <= chk_next(chk, pay_buf[0]);
                    end
                    S_PAYLOAD: begin
                        if (last_payload) begin
                            state <= S_CHK;
                            shreg <= chk;
                        end else begin
                            rd_idx <= rd_idx + 8'd1;
                            shreg  <= pay_buf[rd_nxt];
                            chk    <= chk_next(chk, pay_buf[rd_nxt]);
                        end
                    end
                    default: begin
                        state     <= S_COLLECT;
                        uart_tx_o <= 1'b1;
                        busy_o    <= 1'b0;
                        s_ready_o <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx at default parameters (DIV = 160).
// Honours UART_FRAME_TX_CRC8_EN for the expected CHK bytes.
module tb_uart_frame_tx;
    localparam int DIV = 160;

    typedef logic [7:0] frame_t [0:19];
    typedef struct {
        logic [7:0] pay  [0:3];
        int         np;
        logic [7:0] line [0:7];
        int         nl;
        bit         hold;
    } vec_t;

`ifdef UART_FRAME_TX_CRC8_EN
    localparam logic [7:0] CHK_123 = 8'h72;
    localparam logic [7:0] CHK_FF  = 8'hE6;
    localparam logic [7:0] CHK_55  = 8'hB9;
`else
    localparam logic [7:0] CHK_123 = 8'h03;
    localparam logic [7:0] CHK_FF  = 8'hFE;
    localparam logic [7:0] CHK_55  = 8'h54;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       s_valid_i = 1'b0;
    logic [7:0] s_data_i = 8'h00;
    logic       s_last_i = 1'b0;
    logic       s_ready_o;
    logic       uart_tx_o;
    logic       busy_o;
    logic       trunc_o;

    int n_total = 0;
    int n_pass  = 0;

    uart_frame_tx dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_ready_o (s_ready_o),
        .uart_tx_o (uart_tx_o),
        .busy_o    (busy_o),
        .trunc_o   (trunc_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation did not finish within 95000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Reference CHK over LEN and payload (fr[1..n-1]).
    function automatic logic [7:0] ref_chk(input frame_t fr, input int n);
        logic [7:0] c = 8'h00;
        for (int i = 1; i < n; i++) begin
`ifdef UART_FRAME_TX_CRC8_EN
            c = c ^ fr[i];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
`else
            c = c ^ fr[i];
`endif
        end
        return c;
    endfunction

    // Enter and leave at a falling edge; valid is dropped after the handshake edge.
    task automatic send_byte(input logic [7:0] d, input logic last, output logic tr);
        int waited = 0;
        while (s_ready_o !== 1'b1 && waited < 20000) begin
            @(negedge clk_i);
            waited++;
        end
        check("s_ready before send", 32'(s_ready_o), 32'd1);
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = last;
        #1 tr = trunc_o;
        @(posedge clk_i);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    // Called at the falling edge inside the first start-bit cycle; checks every cycle.
    task automatic check_frame(input string name, input frame_t exp, input int n);
        int line_err = 0;
        int busy_err = 0;
        int rdy_err  = 0;
        logic [7:0] got;
        logic [9:0] bits;
        for (int k = 0; k < n; k++) begin
            bits = {1'b1, exp[k], 1'b0};
            got  = 8'h00;
            for (int j = 0; j < 10; j++) begin
                for (int c = 0; c < DIV; c++) begin
                    if (uart_tx_o !== bits[j]) line_err++;
                    if (busy_o !== 1'b1) busy_err++;
                    if (s_ready_o !== 1'b0) rdy_err++;
                    if (c == DIV / 2 && j >= 1 && j <= 8) got[j-1] = uart_tx_o;
                    @(negedge clk_i);
                end
            end
            check($sformatf("%s byte%0d", name, k), 32'(got), 32'(exp[k]));
        end
        check({name, " bit timing errors"}, line_err, 0);
        check({name, " busy low cycles"}, busy_err, 0);
        check({name, " ready high cycles"}, rdy_err, 0);
        check({name, " busy after end"}, 32'(busy_o), 32'd0);
        check({name, " ready after end"}, 32'(s_ready_o), 32'd1);
        check({name, " line idle after end"}, 32'(uart_tx_o), 32'd1);
    endtask

    initial begin
        vec_t   vecs [0:2];
        frame_t fr;
        logic   tr;
        int     tr_cnt;
        int     low_cnt;

        vecs[0] = '{pay: '{8'h01, 8'h02, 8'h03, 8'h00}, np: 3,
                    line: '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, CHK_123, 8'h00, 8'h00}, nl: 6, hold: 1'b0};
        vecs[1] = '{pay: '{8'hFF, 8'h00, 8'h00, 8'h00}, np: 1,
                    line: '{8'hA5, 8'h01, 8'hFF, CHK_FF, 8'h00, 8'h00, 8'h00, 8'h00}, nl: 4, hold: 1'b1};
        vecs[2] = '{pay: '{8'h55, 8'h00, 8'h00, 8'h00}, np: 1,
                    line: '{8'hA5, 8'h01, 8'h55, CHK_55, 8'h00, 8'h00, 8'h00, 8'h00}, nl: 4, hold: 1'b0};

        // Reset state
        repeat (3) @(negedge clk_i);
        check("reset tx", 32'(uart_tx_o), 32'd1);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset ready", 32'(s_ready_o), 32'd0);
        check("reset trunc", 32'(trunc_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready first cycle after release", 32'(s_ready_o), 32'd1);

        // Table-driven frames
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < vecs[v].np; i++)
                send_byte(vecs[v].pay[i], (i == vecs[v].np - 1), tr);
            if (vecs[v].hold) begin
                s_valid_i = 1'b1;
                s_data_i  = 8'h99;
                s_last_i  = 1'b1;
            end
            fr = '{default: 8'h00};
            for (int i = 0; i < vecs[v].nl; i++) fr[i] = vecs[v].line[i];
            check_frame($sformatf("vec%0d", v), fr, vecs[v].nl);
            s_valid_i = 1'b0;
            s_last_i  = 1'b0;
        end

        // Truncation at MAX_LEN, 0x10 carried into the next frame
        tr_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            send_byte(8'(i), 1'b0, tr);
            if (tr === 1'b1) tr_cnt++;
        end
        check("trunc pulses before 16th byte", tr_cnt, 0);
        send_byte(8'h0F, 1'b0, tr);
        check("trunc on 16th byte", 32'(tr), 32'd1);
        s_valid_i = 1'b1;
        s_data_i  = 8'h10;
        s_last_i  = 1'b0;
        #1 check("trunc after acceptance", 32'(trunc_o), 32'd0);
        fr = '{default: 8'h00};
        fr[0] = 8'hA5;
        fr[1] = 8'h10;
        for (int i = 0; i < 16; i++) fr[2+i] = 8'(i);
        fr[18] = ref_chk(fr, 18);
        check_frame("trunc frame", fr, 19);
        @(posedge clk_i);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        check("ready after 0x10 accepted", 32'(s_ready_o), 32'd1);
        check("busy after 0x10 accepted", 32'(busy_o), 32'd0);
        send_byte(8'h20, 1'b1, tr);
        fr = '{default: 8'h00};
        fr[0] = 8'hA5;
        fr[1] = 8'h02;
        fr[2] = 8'h10;
        fr[3] = 8'h20;
        fr[4] = ref_chk(fr, 4);
        check_frame("carry frame", fr, 5);

        // Reset 500 cycles into the payload byte of a frame
        send_byte(8'hAA, 1'b1, tr);
        repeat (2 * 10 * DIV + 500) @(negedge clk_i);
        check("tx low before mid-frame reset", 32'(uart_tx_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check("mid reset tx", 32'(uart_tx_o), 32'd1);
        check("mid reset busy", 32'(busy_o), 32'd0);
        check("mid reset ready", 32'(s_ready_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready after mid reset release", 32'(s_ready_o), 32'd1);
        low_cnt = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            if (uart_tx_o !== 1'b1 || busy_o !== 1'b0) low_cnt++;
            @(negedge clk_i);
        end
        check("line idle after reset", low_cnt, 0);
        send_byte(8'h55, 1'b1, tr);
        fr = '{default: 8'h00};
        for (int i = 0; i < 4; i++) fr[i] = vecs[2].line[i];
        check_frame("post reset frame", fr, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 20000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 125000, meaning serial bit rate; DIV = CLK_FREQ/BAUD_RATE (160 at defaults).
REQ-003 SHALL have parameter MAX_LEN, default 16, meaning payload buffer depth in bytes (1..255).
REQ-004 SHALL have ports, clock and reset first:
  clk_i  in  1  single clock, all logic rising-edge;
  rst_i  in  1  asynchronous reset, active-high;
  s_valid_i  in  1  payload byte valid;
  s_data_i  in  8  payload byte;
  s_last_i  in  1  marks final payload byte;
  s_ready_o  out  1  byte accepted when s_valid_i and s_ready_o are both high;
  uart_tx_o  out  1  serial line, 8N1, idles high;
  busy_o  out  1  frame being serialised;
  trunc_o  out  1  one-cycle pulse on forced truncation.

Function
REQ-005 SHALL collect payload bytes in COLLECT state into a MAX_LEN buffer; s_ready_o high only in COLLECT.
REQ-006 SHALL close the frame on a handshake with s_last_i=1, or on the MAX_LEN-th byte; in the second case with s_last_i=0 it SHALL pulse trunc_o for the acceptance cycle.
REQ-007 SHALL transmit frame bytes in order: SOF 0xA5, LEN (payload count), payload[0..LEN-1], CHK.
REQ-008 SHALL compute CHK by default as XOR of LEN and all payload bytes, 8-bit.
REQ-009 SHALL sequence states COLLECT -> SOF -> LEN -> PAYLOAD -> CHK -> COLLECT; PAYLOAD repeats until index == LEN-1.
REQ-010 SHALL drive the start bit on the cycle after closing handshake (1-cycle latency).
REQ-011 SHALL serialise each byte as start 0, data LSB first, stop 1, each bit exactly DIV cycles; consecutive frame bytes SHALL have no idle gap (10*DIV cycles per byte).
REQ-012 SHALL hold busy_o high from the first start-bit cycle through the last stop-bit cycle; s_ready_o rises on the cycle after the last stop bit ends.
REQ-013 SHALL ignore s_data_i/s_last_i whenever s_ready_o is low; no byte is lost or duplicated.
REQ-014 SHALL keep the payload index and buffer pointer modulo-free: write pointer saturates at MAX_LEN, read index resets to 0 at each frame.

Reset
REQ-015 SHALL on rst_i asynchronously force: state COLLECT, uart_tx_o=1, s_ready_o=0 while rst_i high then 1 on the first cycle after release, busy_o=0, trunc_o=0, buffer count 0, baud and bit counters 0.
REQ-016 SHALL on reset mid-frame abandon the frame; no partial byte resumes after release.

Configuration
REQ-017 SHALL with macro UART_FRAME_TX_CRC8_EN defined compute CHK as CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, over LEN then payload, MSB first; without it CHK is per REQ-008. Frame format and timing are otherwise identical.

Verification
REQ-018 Payload 0x01,0x02,0x03 (last on 0x03), defaults, macro off -> line bytes A5 03 01 02 03 03, each 1600 cycles, total 9600 cycles, busy_o high for exactly 9600 cycles.
REQ-019 Same payload with UART_FRAME_TX_CRC8_EN -> line bytes A5 03 01 02 03 72.
REQ-020 17 bytes 0x00..0x10 with s_last_i=0 -> trunc_o pulses on byte 0x0F, frame LEN=0x10 carries 0x00..0x0F, 0x10 waits and is accepted as first byte of next frame after s_ready_o returns.
REQ-021 Single byte 0xFF with s_last_i=1 -> start bit next cycle, bytes A5 01 FF FE (macro off); s_valid_i held high during transmit does not change output.
REQ-022 rst_i asserted 500 cycles into payload byte -> uart_tx_o=1 same cycle, busy_o=0, after release new 1-byte frame 0x55 transmits A5 01 55 54 cleanly.
